// File: rtl/nibble_code_lock.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_code_lock
//  Purpose  : Four-digit combination-lock controller for the switch/key front
//             panel. One 4-bit digit is taken from SW on each Enter press and
//             compared against the matching nibble of CODE. A correct sequence
//             opens the lock. Each failed attempt uses up one try. When no
//             tries remain, the lock holds a timed lockout before it returns
//             to entry.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous, active-high
//             SW[3:0]    - digit value, sampled on an accepted press
//             enter      - Enter level (already inverted/synchronised)
//             unlocked   - high while the lock is open
//             error      - one-cycle pulse on a failed attempt
//             locked_out - high while in lockout
//             digit_idx  - index of the next digit to be entered
//             tries_left - remaining attempts
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_code_lock #(
  parameter logic [15:0] CODE           = 16'h6391,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic       enter,
  output logic       unlocked,
  output logic       error,
  output logic       locked_out,
  output logic [1:0] digit_idx,
  output logic [1:0] tries_left
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  ST_ENTRY     = 2'd0;
  localparam logic [1:0]  ST_OPEN      = 2'd1;
  localparam logic [1:0]  ST_LOCKOUT   = 2'd2;

  localparam logic [1:0]  TRIES_RELOAD = 2'(MAX_TRIES);
  localparam logic [1:0]  LAST_DIGIT   = 2'd3;
  localparam logic [15:0] LOCK_LAST    = 16'(LOCKOUT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q,      state_d;
  logic        enter_q;
  logic [1:0]  idx_q,        idx_d;
  logic        mismatch_q,   mismatch_d;
  logic [1:0]  tries_q,      tries_d;
  logic [15:0] cnt_q,        cnt_d;
  logic        error_q,      error_d;
  logic        unlocked_q;
  logic        locked_out_q;

  logic        press;
  logic [3:0]  code_nibble;
  logic        digit_bad;
  logic        attempt_bad;

  // Rising-edge detect on enter. enter_q resets high, so a key that is held
  // through reset does not count as a press once reset is released.
  assign press = enter & ~enter_q;

  // Digit 0 is the most significant nibble of CODE.
  always_comb begin
    code_nibble = CODE[15:12];
    case (idx_q)
      2'd0:    code_nibble = CODE[15:12];
      2'd1:    code_nibble = CODE[11:8];
      2'd2:    code_nibble = CODE[7:4];
      default: code_nibble = CODE[3:0];
    endcase
  end

  assign digit_bad   = (SW != code_nibble);
  // The verdict on the last digit must include that digit's own comparison.
  assign attempt_bad = mismatch_q | digit_bad;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    tries_d    = tries_q;
    cnt_d      = cnt_q;
    error_d    = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (press) begin
          if (idx_q != LAST_DIGIT) begin
            idx_d      = idx_q + 2'd1;
            mismatch_d = attempt_bad;
          end else begin
            // Attempt complete: the digit pointer and mismatch flag start
            // afresh whatever the outcome.
            idx_d      = 2'd0;
            mismatch_d = 1'b0;
            if (!attempt_bad) begin
              state_d = ST_OPEN;
              tries_d = TRIES_RELOAD;
            end else if (tries_q > 2'd1) begin
              tries_d = tries_q - 2'd1;
              error_d = 1'b1;
            end else begin
              // Last try used up. Also covers tries_q==0, so the counter
              // cannot wrap.
              tries_d = 2'd0;
              error_d = 1'b1;
              state_d = ST_LOCKOUT;
              cnt_d   = 16'd0;
            end
          end
        end
      end

      ST_OPEN: begin
        // SW is don't-care here; any press relocks.
        if (press) begin
          state_d    = ST_ENTRY;
          idx_d      = 2'd0;
          mismatch_d = 1'b0;
          tries_d    = TRIES_RELOAD;
        end
      end

      ST_LOCKOUT: begin
        // Presses are ignored. The counter runs 0..LOCKOUT_CYCLES-1, so the
        // lockout lasts exactly LOCKOUT_CYCLES cycles.
        if (cnt_q == LOCK_LAST) begin
          state_d = ST_ENTRY;
          tries_d = TRIES_RELOAD;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = ST_ENTRY;
        idx_d      = 2'd0;
        mismatch_d = 1'b0;
        tries_d    = TRIES_RELOAD;
        cnt_d      = 16'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ENTRY;
      enter_q      <= 1'b1;
      idx_q        <= 2'd0;
      mismatch_q   <= 1'b0;
      tries_q      <= TRIES_RELOAD;
      cnt_q        <= 16'd0;
      error_q      <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      enter_q      <= enter;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      tries_q      <= tries_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      // Status flags are decoded from the next state, so each flag lines up
      // with the state it reports and no output is combinational.
      unlocked_q   <= (state_d == ST_OPEN);
      locked_out_q <= (state_d == ST_LOCKOUT);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign unlocked   = unlocked_q;
  assign error      = error_q;
  assign locked_out = locked_out_q;
  assign digit_idx  = idx_q;
  assign tries_left = tries_q;

endmodule
`default_nettype wire

// File: doc/nibble_code_lock.md
# nibble_code_lock

Four-digit combination-lock controller for the DE1 switch/key front panel. Sequences entry of 4-bit digits from SW[3:0], one per Enter press, and compares each against a stored code nibble. This generalises our single-value switch recognizer into a stateful, multi-step one. It drives unlock/error/lockout LEDs and enforces a retry limit with a timed lockout, and sits between the board I/O top level and the LEDR drivers.

## Interface
Parameters:
- CODE, 16'h6391, four code digits; digit 0 = CODE[15:12], digit 3 = CODE[3:0]
- MAX_TRIES, 3, failed attempts allowed before lockout (legal 1..3)
- LOCKOUT_CYCLES, 50, length of lockout in clock cycles (legal 1..65535)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- SW  input  4  digit value, sampled on an accepted Enter press
- enter  input  1  active-high Enter level (KEY already inverted and synchronised upstream)
- unlocked  output  1  high while in OPEN
- error  output  1  one-cycle pulse on a failed attempt
- locked_out  output  1  high while in LOCKOUT
- digit_idx  output  2  index of the next digit to be entered
- tries_left  output  2  remaining attempts

## Operation
- Press detection: enter_q is a register of enter. press = enter & ~enter_q. On reset enter_q = 1, so a key held through reset is not a press.
- States: ENTRY, OPEN, LOCKOUT. Reset goes to ENTRY.
- Reset values: digit_idx=0, mismatch=0, tries_left=MAX_TRIES, lockout counter=0, unlocked=0, error=0, locked_out=0.
- ENTRY, on press:
  - Compare SW with code nibble[digit_idx]. On inequality, set the mismatch flag (sticky until the attempt ends).
  - digit_idx 0..2: increment digit_idx and stay in ENTRY.
  - digit_idx 3, attempt ends, digit_idx wraps to 0, mismatch clears:
    - No mismatch (including this digit): go to OPEN. tries_left reloads to MAX_TRIES.
    - Mismatch and tries_left>1: decrement tries_left, pulse error, stay in ENTRY.
    - Mismatch and tries_left==1: tries_left becomes 0, pulse error, go to LOCKOUT, clear the lockout counter.
- OPEN: unlocked=1. SW is ignored. A press returns to ENTRY with digit_idx=0 and tries_left=MAX_TRIES (relock). Nothing else leaves OPEN.
- LOCKOUT: locked_out=1. Presses are ignored and do not advance digit_idx. The counter increments every cycle. When the counter reaches LOCKOUT_CYCLES-1, go to ENTRY next edge with tries_left=MAX_TRIES and counter cleared.
- There is no timeout on partial entry. Digits persist indefinitely until completed or reset.
- Lockout counter is 16 bits unsigned. tries_left is 2 bits and never underflows.

## Timing
- All outputs are registered.
- A press sampled at edge N updates digit_idx, tries_left, state and outputs, all visible after edge N.
- A held enter produces exactly one press. A new press needs enter low for at least one cycle.
- Latency from the 4th correct press being sampled to unlocked=1 is one cycle (the register update at that edge).
- error is high for exactly one cycle, coincident with the first cycle of the resulting state (ENTRY or LOCKOUT).
- locked_out is high for exactly LOCKOUT_CYCLES consecutive cycles. The first cycle of ENTRY follows.
- A press in the final LOCKOUT cycle is ignored. A press in the first ENTRY cycle is accepted.
- Reset asserted in any state or mid-entry overrides all else at that edge: values return to reset values and partial digits are discarded.
- Reset with SW or enter active has no other effect.

## Test plan
Bench uses LOCKOUT_CYCLES=8 and default CODE/MAX_TRIES.
- Correct entry: presses with SW=6,3,9,1 → digit_idx 1,2,3,0. unlocked=1 the cycle after the 4th press; error never pulses; tries_left=3.
- Relock and held key: from OPEN, a press → unlocked=0, digit_idx=0. Then enter held 5 cycles with SW=6 → digit_idx advances once only (0→1).
- Single failure: SW=6,3,9,2 → error high exactly one cycle; tries_left=2; digit_idx=0; unlocked=0. Then SW=6,3,9,1 → unlocked=1 and tries_left=3.
- Early mismatch: SW=5,3,9,1 → attempt still takes 4 presses; error on the 4th only; tries_left=2.
- Lockout: three wrong codes → tries_left=0, locked_out high 8 cycles, presses during lockout leave digit_idx=0. Then locked_out=0 and tries_left=3; a correct code afterwards unlocks.
- Reset mid-operation: after SW=6,3 entered, assert reset one cycle → digit_idx=0, all outputs at reset values. Asserting reset during LOCKOUT → locked_out=0 next cycle and tries_left=3.
